host_io_monitor: RTL and testbench

Synthesizable, multi-hart successor to the simulation-only tohost/putchar watcher. It snoops the write port of the AXI RAM (mem_we/waddr/wdata/wstrb) and captures per-hart console characters into per-hart FIFOs, which drain through one round-robin byte stream. It also latches per-hart exit codes from tohost writes and runs a global timeout and cycle counter. It sits beside axi_ram in SoC-level and FPGA builds so that no $display is needed.

---
 rtl/host_io_pkg.sv | 15 +
 rtl/host_io_char_fifo.sv | 58 +++++
 rtl/host_io_monitor.sv | 195 +++++++++++++++++++
 tb/tb_host_io_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/host_io_pkg.sv
// Shared types and helpers for the host I/O monitor: character and drop-counter
// types, the drop-counter ceiling, and an index-width helper that never returns 0.
package host_io_pkg;

    typedef logic [7:0]  char_t;
    typedef logic [15:0] drop_cnt_t;

    localparam drop_cnt_t DROP_MAX = 16'hFFFF;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/host_io_char_fifo.sv
// Per-hart character FIFO. The head is read combinationally so a character can
// move into the output slot on the cycle right after it was pushed. A push while
// full is accepted only if a pop happens in the same cycle.
module host_io_char_fifo
    import host_io_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  srst,
    input  logic  push,
    input  char_t push_data,
    input  logic  pop,
    output char_t head_data,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    char_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (PTR_W + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/host_io_monitor.sv
// Snoops RAM writes for per-hart putchar and tohost traffic. Console bytes are
// buffered per hart and drained round-robin through one registered byte stream;
// exit codes are latched once per hart; a cycle counter and timeout run globally.
module host_io_monitor
    import host_io_pkg::*;
#(
    parameter int              NUM_HARTS      = 2,
    parameter int              ADDR_WIDTH     = 64,
    parameter int              DATA_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE = '0,
    parameter int              FIFO_DEPTH     = 16,
    parameter logic [63:0]     TIMEOUT_CYCLES = 64'd1000000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0]       tohost_addr_i,
    input  logic [NUM_HARTS*ADDR_WIDTH-1:0]       stdout_addr_i,
    input  logic                                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0]                 mem_waddr_i,
    input  logic [DATA_WIDTH-1:0]                 mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]               mem_wstrb_i,
    output logic                                  char_valid_o,
    input  logic                                  char_ready_i,
    output logic [7:0]                            char_data_o,
    output logic [idx_width(NUM_HARTS)-1:0]       char_hart_o,
    output logic [NUM_HARTS*16-1:0]               drop_count_o,
    output logic [NUM_HARTS-1:0]                  exit_valid_o,
    output logic [NUM_HARTS*(DATA_WIDTH-1)-1:0]   exit_code_o,
    output logic                                  all_done_o,
    output logic                                  timeout_o,
    output logic [63:0]                           cycle_count_o
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int HART_W = idx_width(NUM_HARTS);

    logic [ADDR_WIDTH-1:0] abs_addr;
    logic [DATA_WIDTH-1:0] masked_data;
    logic [NUM_HARTS-1:0]  push;
    logic [NUM_HARTS-1:0]  pop;
    logic [NUM_HARTS-1:0]  full;
    logic [NUM_HARTS-1:0]  empty;
    logic [NUM_HARTS-1:0]  exit_set;
    char_t                 push_data [NUM_HARTS];
    char_t                 head_data [NUM_HARTS];

    logic [NUM_HARTS-1:0]               exit_valid_reg;
    logic [NUM_HARTS*(DATA_WIDTH-1)-1:0] exit_code_reg;
    logic                               slot_valid_reg;
    char_t                              slot_data_reg;
    logic [HART_W-1:0]                  slot_hart_reg;
    logic [HART_W-1:0]                  ptr_reg;
    logic [63:0]                        cycle_count_reg;
    logic                               timeout_reg;

    logic              load_en;
    logic              found;
    logic [HART_W-1:0] sel;
    logic [HART_W-1:0] next_ptr;

    assign abs_addr = mem_waddr_i + MEM_BASE;

    // tohost value with unstrobed bytes forced to zero
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_mask
            assign masked_data[gi*8 +: 8] = mem_wstrb_i[gi] ? mem_wdata_i[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
            logic [ADDR_WIDTH-1:0] so_addr;
            logic [ADDR_WIDTH-1:0] th_addr;
            logic [LANE_W-1:0]     lane;
            logic                  so_match;
            logic                  th_match;
            drop_cnt_t             drop_cnt_reg;

            assign so_addr  = stdout_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign th_addr  = tohost_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign lane     = so_addr[LANE_W-1:0];
            // Word match: only the bits above the byte lane take part.
            assign so_match = mem_we_i && (((abs_addr ^ so_addr) >> LANE_W) == '0);
            assign th_match = mem_we_i && (((abs_addr ^ th_addr) >> LANE_W) == '0);

            assign push[gi]      = so_match && mem_wstrb_i[lane];
            assign push_data[gi] = mem_wdata_i[lane*8 +: 8];
            assign exit_set[gi]  = th_match && masked_data[0] && !exit_valid_reg[gi];
            assign pop[gi]       = load_en && found && (sel == HART_W'(gi));

            host_io_char_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk_i),
                .srst      (rst_i),
                .push      (push[gi]),
                .push_data (push_data[gi]),
                .pop       (pop[gi]),
                .head_data (head_data[gi]),
                .full      (full[gi]),
                .empty     (empty[gi])
            );

            // Count characters lost to a full FIFO that is not draining this cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    drop_cnt_reg <= '0;
                end else if (push[gi] && full[gi] && !pop[gi] && drop_cnt_reg != DROP_MAX) begin
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
            end

            assign drop_count_o[gi*16 +: 16] = drop_cnt_reg;
        end
    endgenerate

    // Latch the first odd tohost value per hart; later writes never overwrite it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_valid_reg <= '0;
            exit_code_reg  <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (exit_set[h]) begin
                    exit_valid_reg[h] <= 1'b1;
                    exit_code_reg[h*(DATA_WIDTH-1) +: (DATA_WIDTH-1)] <= masked_data[DATA_WIDTH-1:1];
                end
            end
        end
    end

    // Round-robin pick: first non-empty FIFO at or after the pointer, then wrap.
    always_comb begin
        load_en  = !slot_valid_reg || char_ready_i;
        found    = 1'b0;
        sel      = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (!found && !empty[h] && h >= int'(ptr_reg)) begin
                found = 1'b1;
                sel   = HART_W'(h);
            end
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (!found && !empty[h]) begin
                found = 1'b1;
                sel   = HART_W'(h);
            end
        end
        next_ptr = (sel == HART_W'(NUM_HARTS - 1)) ? '0 : sel + 1'b1;
    end

    // Output slot: refill whenever empty or being consumed, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid_reg <= 1'b0;
            slot_data_reg  <= '0;
            slot_hart_reg  <= '0;
            ptr_reg        <= '0;
        end else if (load_en) begin
            slot_valid_reg <= found;
            if (found) begin
                slot_data_reg <= head_data[sel];
                slot_hart_reg <= sel;
                ptr_reg       <= next_ptr;
            end
        end
    end

    // Cycle counter freezes on completion or timeout; timeout is sticky.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_count_reg <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            if (!all_done_o && !timeout_reg) begin
                cycle_count_reg <= cycle_count_reg + 64'd1;
            end
            if (TIMEOUT_CYCLES != 64'd0 && cycle_count_reg == TIMEOUT_CYCLES - 64'd1 && !all_done_o) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign char_valid_o  = slot_valid_reg;
    assign char_data_o   = slot_data_reg;
    assign char_hart_o   = slot_hart_reg;
    assign exit_valid_o  = exit_valid_reg;
    assign exit_code_o   = exit_code_reg;
    assign all_done_o    = &exit_valid_reg;
    assign timeout_o     = timeout_reg;
    assign cycle_count_o = cycle_count_reg;

endmodule

// File: tb/tb_host_io_monitor.sv
// Directed bench for host_io_monitor: two harts, MEM_BASE offset, short timeout.
// Expected characters go into per-hart queues when written and are popped as the
// output stream delivers them.
module tb_host_io_monitor;

    localparam logic [63:0] MEM_BASE = 64'h100;
    localparam logic [63:0] SO0 = 64'h1000;
    localparam logic [63:0] SO1 = 64'h2003;
    localparam logic [63:0] TH0 = 64'h3008;
    localparam logic [63:0] TH1 = 64'h3000;

    logic         clk = 0;
    logic         rst = 1;
    logic         mem_we = 0;
    logic [63:0]  mem_waddr = '0;
    logic [63:0]  mem_wdata = '0;
    logic [7:0]   mem_wstrb = '0;
    logic         char_ready = 0;
    logic         char_valid;
    logic [7:0]   char_data;
    logic [0:0]   char_hart;
    logic [31:0]  drop_count;
    logic [1:0]   exit_valid;
    logic [125:0] exit_code;
    logic         all_done;
    logic         timeout;
    logic [63:0]  cycle_count;

    int           tests = 0;
    int           fails = 0;
    logic [63:0]  tb_cyc = '0;
    logic [7:0]   exp_q0[$];
    logic [7:0]   exp_q1[$];

    host_io_monitor #(
        .NUM_HARTS      (2),
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .MEM_BASE       (MEM_BASE),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (64'd50)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tohost_addr_i ({TH1, TH0}),
        .stdout_addr_i ({SO1, SO0}),
        .mem_we_i      (mem_we),
        .mem_waddr_i   (mem_waddr),
        .mem_wdata_i   (mem_wdata),
        .mem_wstrb_i   (mem_wstrb),
        .char_valid_o  (char_valid),
        .char_ready_i  (char_ready),
        .char_data_o   (char_data),
        .char_hart_o   (char_hart),
        .drop_count_o  (drop_count),
        .exit_valid_o  (exit_valid),
        .exit_code_o   (exit_code),
        .all_done_o    (all_done),
        .timeout_o     (timeout),
        .cycle_count_o (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clk) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1;
        char_ready = 0;
        mem_we     = 0;
        mem_wstrb  = '0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // One-cycle snooped write at an absolute address; returns at the next negedge.
    task automatic drive_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        mem_we    = 1;
        mem_waddr = addr - MEM_BASE;
        mem_wdata = data;
        mem_wstrb = strb;
        @(negedge clk);
        mem_we    = 0;
        mem_wstrb = '0;
    endtask

    // Compare the current output slot against the scoreboard for its hart.
    task automatic check_head();
        logic [7:0] e;
        if (char_hart == 1'b0) begin
            check("sb_pending_h0", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                check("char_data_h0", char_data, e);
            end
        end else begin
            check("sb_pending_h1", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) begin
                e = exp_q1.pop_front();
                check("char_data_h1", char_data, e);
            end
        end
    endtask

    // Accept one character (bounded wait); want_hart < 0 means any hart.
    task automatic pop_check(input int want_hart);
        int waited = 0;
        char_ready = 1;
        while (char_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("char_valid_wait", char_valid, 1);
        if (char_valid === 1'b1) begin
            if (want_hart >= 0) check("char_hart", char_hart, want_hart);
            check_head();
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] frozen;
        logic [63:0] t0;

        // Reset state
        do_reset();
        check("rst_char_valid", char_valid, 0);
        check("rst_char_data", char_data, 0);
        check("rst_drop", drop_count, 0);
        check("rst_exit_valid", exit_valid, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_all_done", all_done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycle", cycle_count, 0);

        // Exit latching, strobe masking, all_done and counter freeze
        drive_write(TH1, 64'h0, 8'hFF);
        check("exit_even_ignored", exit_valid, 2'b00);
        drive_write(TH1, 64'h7, 8'hFF);
        check("exit1_valid", exit_valid, 2'b10);
        check("exit1_code", exit_code[63 +: 63], 63'h3);
        check("cycle_running", cycle_count, tb_cyc);
        drive_write(TH1, 64'h9, 8'hFF);
        check("exit1_sticky_code", exit_code[63 +: 63], 63'h3);
        check("not_done_yet", all_done, 0);
        drive_write(TH0, 64'hFF05, 8'h01);
        frozen = tb_cyc;
        check("exit0_valid", exit_valid, 2'b11);
        check("exit0_masked_code", exit_code[62:0], 63'h2);
        check("all_done", all_done, 1);
        check("cycle_at_done", cycle_count, frozen);
        repeat (5) @(negedge clk);
        check("cycle_frozen", cycle_count, frozen);
        check("no_timeout_when_done", timeout, 0);

        // Single character, N+2 latency
        do_reset();
        exp_q0.push_back(8'h41);
        drive_write(SO0, 64'h41, 8'h01);
        check("lat_n1_valid", char_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", char_valid, 1);
        pop_check(0);
        check("lat_idle", char_valid, 0);

        // Byte lane selection and lane strobe gating
        exp_q1.push_back(8'h42);
        drive_write(64'h2000, 64'h1122_3344_4299_8877, 8'h08);
        pop_check(1);
        drive_write(64'h2000, 64'h1122_3344_4299_8877, 8'h01);
        repeat (3) @(negedge clk);
        check("lane_unstrobed_no_char", char_valid, 0);

        // Backpressure and overflow
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 17) exp_q0.push_back(8'(8'h60 + i));
            drive_write(SO0, 64'(8'h60 + i), 8'h01);
        end
        check("ovf_drop0", drop_count[15:0], 16'd3);
        check("ovf_drop1", drop_count[31:16], 16'd0);
        check("ovf_slot_valid", char_valid, 1);
        check_head();
        // Push into the full FIFO on the same edge it pops: must be kept
        exp_q0.push_back(8'h74);
        char_ready = 1;
        drive_write(SO0, 64'h74, 8'h01);
        check("full_push_with_pop", drop_count[15:0], 16'd3);
        for (int i = 0; i < 17; i++) pop_check(0);
        repeat (2) @(negedge clk);
        check("ovf_drained", char_valid, 0);

        // Round-robin order and one-per-cycle throughput
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q0.push_back(8'(8'h70 + i));
            drive_write(SO0, 64'(8'h70 + i), 8'h01);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q1.push_back(8'(8'h80 + i));
            drive_write(64'h2000, 64'(8'h80 + i) << 24, 8'h08);
        end
        t0 = tb_cyc;
        for (int i = 0; i < 6; i++) pop_check(i % 2);
        check("rr_throughput", tb_cyc - t0, 6);

        // Timeout at cycle 50, sticky, counter frozen
        do_reset();
        while (tb_cyc < 64'd49) @(negedge clk);
        check("to_before", timeout, 0);
        check("to_cycle49", cycle_count, 49);
        @(negedge clk);
        check("to_rise", timeout, 1);
        check("to_cycle50", cycle_count, 50);
        repeat (10) @(negedge clk);
        check("to_sticky", timeout, 1);
        check("to_frozen", cycle_count, 50);

        // Reset mid-operation discards buffered characters and exits
        drive_write(SO0, 64'h55, 8'h01);
        drive_write(SO0, 64'h56, 8'h01);
        drive_write(TH1, 64'h3, 8'hFF);
        do_reset();
        check("mid_rst_valid", char_valid, 0);
        check("mid_rst_exit", exit_valid, 0);
        check("mid_rst_code", exit_code, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_cycle", cycle_count, 0);
        char_ready = 1;
        repeat (5) @(negedge clk);
        check("mid_rst_fifo_empty", char_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
